// File: rtl/pkg_pack_if.sv
// pkg_pack_if: packet word stream toward the UART stage plus the fx
// register bus. master = packet assembler side, slave = its peer.
interface pkg_pack_if;
  logic [15:0] pkg_d;
  logic        pkg_vld;
  logic        pkg_rdy;
  logic        pkg_done;
  logic [21:0] fx_waddr;
  logic        fx_wr;
  logic [7:0]  fx_data;
  logic [21:0] fx_raddr;
  logic        fx_rd;
  logic [7:0]  fx_q;

  modport master (
    output pkg_d, pkg_vld, pkg_done, fx_q,
    input  pkg_rdy, fx_waddr, fx_wr, fx_data,
    input  fx_raddr, fx_rd
  );

  modport slave (
    input  pkg_d, pkg_vld, pkg_done, fx_q,
    output pkg_rdy, fx_waddr, fx_wr, fx_data,
    output fx_raddr, fx_rd
  );
endinterface

// File: rtl/pkg_pack.sv
// pkg_pack: snapshots eight smoothed channels and streams an 11-word
// framed packet (header, sequence, samples, checksum) to the UART stage.
module pkg_pack #(
  parameter logic [15:0] HDR   = 16'hEB90,
  parameter int unsigned NWORD = 11
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [15:0] sm1_data,
  input  logic [15:0] sm2_data,
  input  logic [15:0] sm3_data,
  input  logic [15:0] sm4_data,
  input  logic [15:0] sm5_data,
  input  logic [15:0] sm6_data,
  input  logic [15:0] sm7_data,
  input  logic [15:0] sm8_data,
  input  logic        sm_vld,
  input  logic [5:0]  dev_id,
  pkg_pack_if.master  bus
);

  localparam logic [3:0] LAST = 4'(NWORD - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e      st_q;
  logic        vld_q;
  logic [15:0] d_q;
  logic [3:0]  idx_q;
  logic [15:0] chk_q;
  logic [15:0] seq_q;
  logic [15:0] smp_q [8];
  logic [15:0] smp_in [8];

  logic        en_q;
  logic [7:0]  dec_q;
  logic [7:0]  dcnt_q, dcnt_d;
  logic [7:0]  drop_q, drop_d;
  logic [7:0]  fxq_q;
  logic [7:0]  rdata;

  logic        wsel, rsel;
  logic        wr_ctrl, wr_dec, wr_drop;
  logic        due, xfer, last, cap;
  logic [3:0]  nidx;
  logic [2:0]  sidx;
  logic [15:0] nword;
  logic        unused_addr;

  always_comb begin
    smp_in[0] = sm1_data;
    smp_in[1] = sm2_data;
    smp_in[2] = sm3_data;
    smp_in[3] = sm4_data;
    smp_in[4] = sm5_data;
    smp_in[5] = sm6_data;
    smp_in[6] = sm7_data;
    smp_in[7] = sm8_data;
  end

  assign wsel    = bus.fx_wr && (bus.fx_waddr[21:16] == dev_id);
  assign rsel    = bus.fx_rd && (bus.fx_raddr[21:16] == dev_id);
  assign wr_ctrl = wsel && (bus.fx_waddr[7:0] == 8'h00);
  assign wr_dec  = wsel && (bus.fx_waddr[7:0] == 8'h01);
  assign wr_drop = wsel && (bus.fx_waddr[7:0] == 8'h04);

  assign unused_addr = ^{bus.fx_waddr[15:8], bus.fx_raddr[15:8]};

  assign due  = en_q && sm_vld && (dcnt_q == dec_q);
  assign xfer = (st_q == SEND) && bus.pkg_rdy;
  assign last = xfer && (idx_q == LAST);
  // the final-word cycle frees the buffer, so a due strobe there is kept
  assign cap  = due && ((st_q == IDLE) || last);

  assign nidx = idx_q + 4'd1;
  assign sidx = nidx[2:0] - 3'd2;

  always_comb begin
    nword = smp_q[sidx];
    if (nidx == 4'd1)
      nword = seq_q;
    else if (nidx == LAST)
      nword = chk_q;
  end

  always_comb begin
    dcnt_d = dcnt_q;
    if (wr_dec || (wr_ctrl && !bus.fx_data[0]))
      dcnt_d = '0;
    else if (en_q && sm_vld)
      dcnt_d = due ? 8'd0 : dcnt_q + 8'd1;
  end

  always_comb begin
    drop_d = drop_q;
    if (wr_drop)
      drop_d = '0;
    else if (due && !cap && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      bus.fx_raddr[7:0] == 8'h00: rdata = {7'd0, en_q};
      bus.fx_raddr[7:0] == 8'h01: rdata = dec_q;
      bus.fx_raddr[7:0] == 8'h02: rdata = seq_q[7:0];
      bus.fx_raddr[7:0] == 8'h03: rdata = seq_q[15:8];
      bus.fx_raddr[7:0] == 8'h04: rdata = drop_q;
      default:                    rdata = '0;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      en_q   <= 1'b0;
      dec_q  <= '0;
      dcnt_q <= '0;
      drop_q <= '0;
      fxq_q  <= '0;
    end else begin
      if (wr_ctrl) en_q <= bus.fx_data[0];
      if (wr_dec) dec_q <= bus.fx_data;
      dcnt_q <= dcnt_d;
      drop_q <= drop_d;
      fxq_q  <= rsel ? rdata : 8'd0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      st_q  <= IDLE;
      vld_q <= 1'b0;
      d_q   <= '0;
      idx_q <= '0;
      chk_q <= '0;
      seq_q <= '0;
      smp_q <= '{default: '0};
    end else begin
      if (last) seq_q <= seq_q + 16'd1;
      if (cap) begin
        st_q  <= SEND;
        vld_q <= 1'b1;
        d_q   <= HDR;
        idx_q <= '0;
        chk_q <= '0;
        smp_q <= smp_in;
      end else begin
        unique case (st_q)
          IDLE: begin
            vld_q <= 1'b0;
          end
          SEND: begin
            if (last) begin
              st_q  <= IDLE;
              vld_q <= 1'b0;
              d_q   <= '0;
            end else if (xfer) begin
              idx_q <= nidx;
              d_q   <= nword;
              if (nidx != LAST) chk_q <= chk_q + nword;
            end
          end
          default: st_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.pkg_d    = d_q;
  assign bus.pkg_vld  = vld_q;
  assign bus.pkg_done = last;
  assign bus.fx_q     = fxq_q;

endmodule

// File: tb/tb_pkg_pack.sv
// tb_pkg_pack: randomized bench for pkg_pack against a packet-level
// reference model of capture, decimation, drop and framing rules.
module tb_pkg_pack;

  localparam logic [15:0] HDR = 16'hEB90;
  localparam logic [5:0]  ID  = 6'h2A;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] smp [8];
  logic        sm_vld = 1'b0;
  logic [5:0]  dev_id = ID;

  pkg_pack_if bus();

  pkg_pack dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .sm1_data (smp[0]),
    .sm2_data (smp[1]),
    .sm3_data (smp[2]),
    .sm4_data (smp[3]),
    .sm5_data (smp[4]),
    .sm6_data (smp[5]),
    .sm7_data (smp[6]),
    .sm8_data (smp[7]),
    .sm_vld   (sm_vld),
    .dev_id   (dev_id),
    .bus      (bus.master)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_err = 0;

  logic [16:0] obs_q[$];
  logic [16:0] exp_q[$];
  int          stall_err = 0;
  int          spur_done = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_d = '0;

  // packet-level reference model state
  bit          m_en, m_busy;
  logic [7:0]  m_dec, m_dcnt, m_drop;
  logic [15:0] m_seq;
  int          m_pos;

  always @(negedge clk_sys) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bus.pkg_vld || bus.pkg_d !== prev_d))
        stall_err++;
      if (bus.pkg_vld && bus.pkg_rdy)
        obs_q.push_back({bus.pkg_done, bus.pkg_d});
      else if (bus.pkg_done)
        spur_done++;
      prev_stall = bus.pkg_vld && !bus.pkg_rdy;
      prev_d = bus.pkg_d;
    end
  end

  task automatic push_pkt(input logic [15:0] s);
    logic [15:0] sum;
    sum = s;
    exp_q.push_back({1'b0, HDR});
    exp_q.push_back({1'b0, s});
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({1'b0, smp[k]});
      sum = sum + smp[k];
    end
    exp_q.push_back({1'b1, sum});
  endtask

  task automatic tick();
    bit last, due, cap;
    logic wsel;
    logic [7:0] off;
    if (rst) begin
      m_en = 0; m_busy = 0; m_pos = 0;
      m_dec = 0; m_dcnt = 0; m_drop = 0; m_seq = 0;
    end else begin
      last = m_busy && (m_pos == 10) && bus.pkg_rdy;
      due  = m_en && sm_vld && (m_dcnt == m_dec);
      cap  = due && (!m_busy || last);
      if (m_busy && bus.pkg_rdy) m_pos++;
      if (last) begin
        m_busy = 0;
        m_seq = m_seq + 16'd1;
      end
      if (due && !cap && m_drop != 8'hFF) m_drop++;
      if (m_en && sm_vld) m_dcnt = due ? 8'd0 : m_dcnt + 8'd1;
      wsel = bus.fx_wr && (bus.fx_waddr[21:16] == ID);
      off = bus.fx_waddr[7:0];
      if (wsel && off == 8'h04) m_drop = 0;
      if (wsel && off == 8'h00) begin
        m_en = bus.fx_data[0];
        if (!bus.fx_data[0]) m_dcnt = 0;
      end
      if (wsel && off == 8'h01) begin
        m_dec = bus.fx_data;
        m_dcnt = 0;
      end
      if (cap) begin
        push_pkt(m_seq);
        m_busy = 1;
        m_pos = 0;
      end
    end
    @(posedge clk_sys);
    #1;
    sm_vld = 1'b0;
    bus.fx_wr = 1'b0;
    bus.fx_rd = 1'b0;
  endtask

  task automatic fx_write(input logic [7:0] off, input logic [7:0] v);
    bus.fx_waddr = {ID, 8'h00, off};
    bus.fx_data = v;
    bus.fx_wr = 1'b1;
    tick();
  endtask

  task automatic fx_read(input logic [5:0] id, input logic [7:0] off,
                         output logic [7:0] v);
    bus.fx_raddr = {id, 8'h00, off};
    bus.fx_rd = 1'b1;
    tick();
    v = bus.fx_q;
  endtask

  function automatic int first_diff();
    int n;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (obs_q[i] !== exp_q[i]) return i;
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [16:0] obs_at(input int i);
    return (i >= 0 && i < obs_q.size()) ? obs_q[i] : 17'h0;
  endfunction

  function automatic logic [16:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 17'h0;
  endfunction

  task automatic test_reset();
    logic [7:0] v;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.pkg_vld !== 1'b0) begin
      n_err++;
      $display("FAIL reset_vld: got %b want 0", bus.pkg_vld);
    end
    n_cmp++;
    if (bus.pkg_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done: got %b want 0", bus.pkg_done);
    end
    n_cmp++;
    if (bus.pkg_d !== 16'h0) begin
      n_err++;
      $display("FAIL reset_d: got %h want 0000", bus.pkg_d);
    end
    n_cmp++;
    if (bus.fx_q !== 8'h0) begin
      n_err++;
      $display("FAIL reset_fxq: got %h want 00", bus.fx_q);
    end
    rst = 1'b0;
    for (int r = 0; r < 5; r++) begin
      fx_read(ID, 8'(r), v);
      n_cmp++;
      if (v !== 8'h0) begin
        n_err++;
        $display("FAIL reset_reg%0d: got %h want 00", r, v);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] gold [11];
    logic [16:0] want;
    logic [7:0]  v;
    int d;
    bus.pkg_rdy = 1'b1;
    fx_write(8'h00, 8'h01);
    fx_write(8'h01, 8'h00);
    for (int k = 0; k < 8; k++) smp[k] = 16'(k + 1);
    obs_q.delete();
    exp_q.delete();
    sm_vld = 1'b1;
    tick();
    n_cmp++;
    if (bus.pkg_vld !== 1'b1 || bus.pkg_d !== HDR) begin
      n_err++;
      $display("FAIL basic_latency: got vld=%b d=%h want 1/%h",
               bus.pkg_vld, bus.pkg_d, HDR);
    end
    repeat (11) tick();
    gold[0] = HDR;
    gold[1] = 16'h0000;
    for (int k = 0; k < 8; k++) gold[k+2] = 16'(k + 1);
    gold[10] = 16'h0024;
    for (int i = 0; i < 11; i++) begin
      want = {(i == 10), gold[i]};
      n_cmp++;
      if (obs_at(i) !== want || obs_q.size() != 11) begin
        n_err++;
        $display("FAIL basic_word%0d: got %h want %h (count %0d)",
                 i, obs_at(i), want, obs_q.size());
      end
    end
    d = first_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL basic_model: idx %0d got %h want %h",
               d, obs_at(d), exp_at(d));
    end
    n_cmp++;
    if (bus.pkg_vld !== 1'b0) begin
      n_err++;
      $display("FAIL basic_idle: got vld=%b want 0", bus.pkg_vld);
    end
    fx_read(ID, 8'h02, v);
    n_cmp++;
    if (v !== 8'h01) begin
      n_err++;
      $display("FAIL basic_seq_l: got %h want 01", v);
    end
    fx_read(ID, 8'h03, v);
    n_cmp++;
    if (v !== 8'h00) begin
      n_err++;
      $display("FAIL basic_seq_h: got %h want 00", v);
    end
    fx_read(ID ^ 6'h01, 8'h00, v);
    n_cmp++;
    if (v !== 8'h00) begin
      n_err++;
      $display("FAIL basic_other_id: got %h want 00", v);
    end
  endtask

  task automatic test_decimation();
    logic [15:0] ch1_4, ch1_8;
    int d;
    bus.pkg_rdy = 1'b1;
    fx_write(8'h01, 8'd3);
    obs_q.delete();
    exp_q.delete();
    ch1_4 = '0;
    ch1_8 = '0;
    for (int s = 1; s <= 8; s++) begin
      for (int k = 0; k < 8; k++) smp[k] = 16'($urandom);
      if (s == 4) ch1_4 = smp[0];
      if (s == 8) ch1_8 = smp[0];
      sm_vld = 1'b1;
      tick();
      repeat (19) tick();
    end
    n_cmp++;
    if (obs_q.size() != 22) begin
      n_err++;
      $display("FAIL dec_count: got %0d words want 22", obs_q.size());
    end
    n_cmp++;
    if (obs_at(2) !== {1'b0, ch1_4} || obs_at(13) !== {1'b0, ch1_8}) begin
      n_err++;
      $display("FAIL dec_which: got %h/%h want %h/%h",
               obs_at(2), obs_at(13), ch1_4, ch1_8);
    end
    d = first_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL dec_model: idx %0d got %h want %h",
               d, obs_at(d), exp_at(d));
    end
  endtask

  task automatic test_stall();
    logic [7:0] v;
    int d;
    fx_write(8'h01, 8'd0);
    obs_q.delete();
    exp_q.delete();
    stall_err = 0;
    spur_done = 0;
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 8; k++) smp[k] = 16'($urandom);
      sm_vld = 1'b1;
      for (int c = 0; c < 40; c++) begin
        bus.pkg_rdy = 1'($urandom_range(0, 1));
        tick();
      end
    end
    bus.pkg_rdy = 1'b1;
    repeat (12) tick();
    d = first_diff();
    n_cmp++;
    if (d != -1 || obs_q.size() < 11) begin
      n_err++;
      $display("FAIL stall_model: idx %0d got %h want %h (count %0d)",
               d, obs_at(d), exp_at(d), obs_q.size());
    end
    n_cmp++;
    if (stall_err != 0) begin
      n_err++;
      $display("FAIL stall_stable: got %0d violations want 0", stall_err);
    end
    n_cmp++;
    if (spur_done != 0) begin
      n_err++;
      $display("FAIL stall_done: got %0d stray pulses want 0", spur_done);
    end
    fx_read(ID, 8'h04, v);
    n_cmp++;
    if (v !== m_drop) begin
      n_err++;
      $display("FAIL stall_drop: got %h want %h", v, m_drop);
    end
  endtask

  task automatic test_drop();
    logic [7:0] v;
    int d;
    bus.pkg_rdy = 1'b1;
    fx_write(8'h04, 8'h5A);
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < 8; k++) smp[k] = 16'($urandom);
      sm_vld = 1'b1;
      tick();
      repeat (4) tick();
    end
    repeat (12) tick();
    fx_read(ID, 8'h04, v);
    n_cmp++;
    if (v !== 8'd20 || v !== m_drop) begin
      n_err++;
      $display("FAIL drop_count: got %0d want 20 (model %0d)", v, m_drop);
    end
    for (int i = 0; i < 420; i++) begin
      for (int k = 0; k < 8; k++) smp[k] = 16'($urandom);
      sm_vld = 1'b1;
      tick();
      repeat (4) tick();
    end
    repeat (12) tick();
    fx_read(ID, 8'h04, v);
    n_cmp++;
    if (v !== 8'hFF) begin
      n_err++;
      $display("FAIL drop_sat: got %h want ff", v);
    end
    d = first_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL drop_model: idx %0d got %h want %h",
               d, obs_at(d), exp_at(d));
    end
    fx_write(8'h04, 8'h00);
    sm_vld = 1'b1;
    tick();
    tick();
    // due strobe dropped mid-packet in the same cycle as a DROP write
    sm_vld = 1'b1;
    bus.fx_waddr = {ID, 8'h00, 8'h04};
    bus.fx_data = 8'h11;
    bus.fx_wr = 1'b1;
    tick();
    repeat (12) tick();
    fx_read(ID, 8'h04, v);
    n_cmp++;
    if (v !== 8'h00) begin
      n_err++;
      $display("FAIL drop_clear_wins: got %h want 00", v);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    int gaps, d;
    bus.pkg_rdy = 1'b1;
    obs_q.delete();
    exp_q.delete();
    gaps = 0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 8; k++) smp[k] = 16'($urandom);
      sm_vld = 1'b1;
      tick();
      if (bus.pkg_vld !== 1'b1) gaps++;
      for (int c = 0; c < 10; c++) begin
        tick();
        if (bus.pkg_vld !== 1'b1) gaps++;
      end
    end
    repeat (12) tick();
    n_cmp++;
    if (gaps != 0) begin
      n_err++;
      $display("FAIL b2b_gap: got %0d idle cycles want 0", gaps);
    end
    n_cmp++;
    if (obs_q.size() != 33) begin
      n_err++;
      $display("FAIL b2b_count: got %0d words want 33", obs_q.size());
    end
    d = first_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL b2b_model: idx %0d got %h want %h",
               d, obs_at(d), exp_at(d));
    end
    fx_read(ID, 8'h04, v);
    n_cmp++;
    if (v !== 8'h00) begin
      n_err++;
      $display("FAIL b2b_drop: got %h want 00", v);
    end
  endtask

  task automatic test_seq_wrap();
    logic [7:0]  v;
    logic [15:0] sum;
    int d;
    bus.pkg_rdy = 1'b1;
    obs_q.delete();
    exp_q.delete();
    force dut.seq_q = 16'hFFFF;
    #2;
    release dut.seq_q;
    m_seq = 16'hFFFF;
    for (int k = 0; k < 8; k++) smp[k] = 16'($urandom);
    sum = 16'hFFFF;
    for (int k = 0; k < 8; k++) sum = sum + smp[k];
    sm_vld = 1'b1;
    tick();
    repeat (12) tick();
    n_cmp++;
    if (obs_at(1) !== {1'b0, 16'hFFFF}) begin
      n_err++;
      $display("FAIL wrap_seqword: got %h want 0ffff", obs_at(1));
    end
    n_cmp++;
    if (obs_at(10) !== {1'b1, sum}) begin
      n_err++;
      $display("FAIL wrap_chk: got %h want %h", obs_at(10), {1'b1, sum});
    end
    d = first_diff();
    n_cmp++;
    if (d != -1) begin
      n_err++;
      $display("FAIL wrap_model: idx %0d got %h want %h",
               d, obs_at(d), exp_at(d));
    end
    fx_read(ID, 8'h02, v);
    n_cmp++;
    if (v !== 8'h00) begin
      n_err++;
      $display("FAIL wrap_seq_l: got %h want 00", v);
    end
    fx_read(ID, 8'h03, v);
    n_cmp++;
    if (v !== 8'h00) begin
      n_err++;
      $display("FAIL wrap_seq_h: got %h want 00", v);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    bus.pkg_rdy = 1'b1;
    fx_write(8'h01, 8'd0);
    obs_q.delete();
    exp_q.delete();
    for (int k = 0; k < 8; k++) smp[k] = 16'($urandom);
    sm_vld = 1'b1;
    tick();
    repeat (5) tick();
    n_cmp++;
    if (bus.pkg_vld !== 1'b1 || {1'b0, bus.pkg_d} !== exp_at(5)) begin
      n_err++;
      $display("FAIL mid_word5: got %b/%h want 1/%h",
               bus.pkg_vld, bus.pkg_d, exp_at(5));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.pkg_vld !== 1'b0 || bus.pkg_done !== 1'b0 || bus.pkg_d !== 16'h0) begin
      n_err++;
      $display("FAIL mid_abort: got vld=%b done=%b d=%h want 0/0/0000",
               bus.pkg_vld, bus.pkg_done, bus.pkg_d);
    end
    for (int r = 0; r < 5; r++) begin
      fx_read(ID, 8'(r), v);
      n_cmp++;
      if (v !== 8'h00) begin
        n_err++;
        $display("FAIL mid_reg%0d: got %h want 00", r, v);
      end
    end
    fx_write(8'h10, 8'hA5);
    fx_read(ID, 8'h10, v);
    n_cmp++;
    if (v !== 8'h00) begin
      n_err++;
      $display("FAIL mid_unmapped: got %h want 00", v);
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) smp[k] = '0;
    bus.pkg_rdy  = 1'b0;
    bus.fx_waddr = '0;
    bus.fx_wr    = 1'b0;
    bus.fx_data  = '0;
    bus.fx_raddr = '0;
    bus.fx_rd    = 1'b0;
    test_reset();
    test_basic();
    test_decimation();
    test_stall();
    test_drop();
    test_back_to_back();
    test_seq_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
